// File: rtl/des_pkg.sv
// DES constant tables, state encoding and the bit-permutation helpers shared by the iterative engine.
// Bit 1 is the MSB of every vector, matching the published DES tables.
package des_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  localparam int CNT_W = 5;

  localparam int IP [1:64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP [1:64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int PC1 [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [1:48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  localparam int E [1:48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P [1:32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int SHIFT [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Each S-box row-major: entry index = {b1,b6} * 16 + {b2..b5}
  localparam int SBOX [0:7][0:63] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [1:64] ip_perm(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 1; i <= 64; i++) y[i] = x[IP[i]];
    return y;
  endfunction

  function automatic logic [1:64] fp_perm(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 1; i <= 64; i++) y[i] = x[FP[i]];
    return y;
  endfunction

  function automatic logic [1:56] pc1_perm(input logic [1:64] x);
    logic [1:56] y;
    for (int i = 1; i <= 56; i++) y[i] = x[PC1[i]];
    return y;
  endfunction

  function automatic logic [1:48] pc2_perm(input logic [1:56] x);
    logic [1:48] y;
    for (int i = 1; i <= 48; i++) y[i] = x[PC2[i]];
    return y;
  endfunction

  function automatic logic [1:48] e_perm(input logic [1:32] x);
    logic [1:48] y;
    for (int i = 1; i <= 48; i++) y[i] = x[E[i]];
    return y;
  endfunction

  function automatic logic [1:32] p_perm(input logic [1:32] x);
    logic [1:32] y;
    for (int i = 1; i <= 32; i++) y[i] = x[P[i]];
    return y;
  endfunction

  function automatic logic [1:32] sbox_sub(input logic [1:48] x);
    logic [1:32] y;
    logic [1:6]  b;
    logic [5:0]  idx;
    for (int j = 0; j < 8; j++) begin
      b   = x[6*j+1 +: 6];
      idx = {b[1], b[6], b[2], b[3], b[4], b[5]};
      y[4*j+1 +: 4] = 4'(SBOX[j][idx]);
    end
    return y;
  endfunction

  function automatic logic [1:28] rotl28(input logic [1:28] x, input int n);
    return (n == 1) ? {x[2:28], x[1]} : {x[3:28], x[1:2]};
  endfunction

  function automatic logic [1:28] rotr28(input logic [1:28] x, input int n);
    return (n == 1) ? {x[28], x[1:27]} : {x[27:28], x[1:26]};
  endfunction

endpackage

// File: rtl/des_iter_engine_if.sv
// Block-in / result-out handshake bundle for the iterative DES engine.
interface des_iter_engine_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_decrypt;
    logic [1:64] in_data;
    logic [1:64] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [1:64] out_data;
    logic        busy;

    modport master (
        output in_valid, in_decrypt, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_decrypt, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/des_round.sv
// One combinational DES Feistel round: f(R, K) followed by the L/R swap and XOR.
module des_round
    import des_pkg::*;
(
    input  logic [1:32] l_i,
    input  logic [1:32] r_i,
    input  logic [1:48] k_i,
    output logic [1:32] l_o,
    output logic [1:32] r_o
);
    assign l_o = r_i;
    assign r_o = l_i ^ p_perm(sbox_sub(e_perm(r_i) ^ k_i));
endmodule

// File: rtl/des_iter_engine.sv
// Iterative DES: one Feistel round per clock, 16 rounds per block, with handshake
// sequencing and an on-the-fly key schedule (left rotations to encrypt, right to decrypt).
module des_iter_engine
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic               clk,
    input  logic               rst,
    des_iter_engine_if.slave   bus
);
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic [1:32]        l_q, l_d, r_q, r_d;
    logic [1:28]        c_q, c_d, d_q, d_d;
    logic [1:28]        c_rot, d_rot;
    logic [CNT_W-1:0]   sidx;
    logic [1:48]        subkey;
    logic [1:32]        l_nxt, r_nxt;

    // Decrypt round 1 uses the unrotated C||D (K16); later rounds walk the schedule backwards
    always_comb begin
        c_rot = c_q;
        d_rot = d_q;
        sidx  = '0;
        if (state_q == ROUND) begin
            if (!mode_q) begin
                c_rot = rotl28(c_q, SHIFT[cnt_q]);
                d_rot = rotl28(d_q, SHIFT[cnt_q]);
            end else if (cnt_q != CNT_W'(1)) begin
                sidx  = CNT_W'(18) - cnt_q;
                c_rot = rotr28(c_q, SHIFT[sidx]);
                d_rot = rotr28(d_q, SHIFT[sidx]);
            end
        end
    end

    assign subkey = pc2_perm({c_rot, d_rot});

    des_round u_round (
        .l_i (l_q),
        .r_i (r_q),
        .k_i (subkey),
        .l_o (l_nxt),
        .r_o (r_nxt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    {l_d, r_d} = ip_perm(bus.in_data);
                    {c_d, d_d} = pc1_perm(bus.in_key);
                    mode_d     = bus.in_decrypt;
                    cnt_d      = CNT_W'(1);
                    state_d    = ROUND;
                end
            end
            ROUND: begin
                l_d = l_nxt;
                r_d = r_nxt;
                c_d = c_rot;
                d_d = d_rot;
                if (cnt_q == CNT_W'(NUM_ROUNDS)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
        end
    end

    // The final swap is undone here: output is FP(R16 || L16)
    assign bus.out_data  = fp_perm({r_q, l_q});
    assign bus.out_valid = (state_q == DONE);
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_des_iter_engine.sv
// Directed bench for des_iter_engine: known-answer vectors, latency, back-pressure,
// back-to-back issue and mid-operation reset.
module tb_des_iter_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    des_iter_engine_if bus ();

    des_iter_engine #(.NUM_ROUNDS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] key;
        logic [63:0] data;
        logic        dec;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [4];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge right after the accept edge
    task automatic issue(input vec_t v);
        int i;
        i = 0;
        while (!bus.in_ready && i < 50) begin
            @(negedge clk);
            i++;
        end
        if (i >= 50) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        bus.in_valid   = 1'b1;
        bus.in_key     = v.key;
        bus.in_data    = v.data;
        bus.in_decrypt = v.dec;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.in_key     = {$urandom, $urandom};
        bus.in_data    = {$urandom, $urandom};
        bus.in_decrypt = ~v.dec;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake(input string name);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({name, "_after_hs"}, 64'({bus.out_valid, bus.in_ready, bus.busy}), 64'b010);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat;
        issue(v);
        wait_result(lat);
        chk({name, "_latency"}, 64'(lat), 64'd16);
        chk({name, "_data"}, bus.out_data, v.exp);
        chk({name, "_done_flags"}, 64'({bus.in_ready, bus.busy}), 64'b01);
        handshake(name);
    endtask

    initial begin
        int   lat;
        logic seen;

        vecs[0] = '{key: 64'h133457799BBCDFF1, data: 64'h0123456789ABCDEF, dec: 1'b0, exp: 64'h85E813540F0AB405};
        vecs[1] = '{key: 64'h133457799BBCDFF1, data: 64'h85E813540F0AB405, dec: 1'b1, exp: 64'h0123456789ABCDEF};
        vecs[2] = '{key: 64'h0E329232EA6D0D73, data: 64'h8787878787878787, dec: 1'b0, exp: 64'h0000000000000000};
        vecs[3] = '{key: 64'h0E329232EA6D0D73, data: 64'h0000000000000000, dec: 1'b1, exp: 64'h8787878787878787};

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_decrypt = 1'b0;
        bus.in_data    = '0;
        bus.in_key     = '0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_held_flags", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b000);
        rst = 1'b0;
        #1;
        chk("reset_flags", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
        chk("reset_out_data", bus.out_data, 64'd0);
        @(negedge clk);

        for (int k = 0; k < 4; k++) run_vec($sformatf("vec%0d", k), vecs[k]);

        // Back-pressure, with a second block offered throughout DONE
        issue(vecs[0]);
        wait_result(lat);
        chk("bp_latency", 64'(lat), 64'd16);
        bus.in_valid   = 1'b1;
        bus.in_key     = vecs[2].key;
        bus.in_data    = vecs[2].data;
        bus.in_decrypt = vecs[2].dec;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_data%0d", c), bus.out_data, vecs[0].exp);
            chk($sformatf("bp_hold_flags%0d", c), 64'({bus.out_valid, bus.in_ready}), 64'b10);
        end
        handshake("bp");
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_key   = {$urandom, $urandom};
        bus.in_data  = {$urandom, $urandom};
        chk("b2b_accepted", 64'({bus.in_ready, bus.busy}), 64'b01);
        wait_result(lat);
        chk("b2b_latency", 64'(lat), 64'd16);
        chk("b2b_data", bus.out_data, vecs[2].exp);
        handshake("b2b");

        // Reset while round 7 is being applied
        issue(vecs[0]);
        repeat (6) @(negedge clk);
        chk("pre_rst_busy", 64'({bus.busy, bus.out_valid}), 64'b10);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_flags", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
        chk("midrst_out_data", bus.out_data, 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("midrst_no_stale", 64'(seen), 64'd0);
        run_vec("post_rst", vecs[2]);
        run_vec("post_rst_enc", vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
